// File: rtl/iopage_pkg.sv
// Shared types and constants for the I/O-page bus fabric.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iopage_pkg;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_WAIT = 2'd1,
        B_DONE = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_POST = 2'd1,
        I_HOLD = 2'd2
    } irq_state_t;

    // Read data returned when no slave answers in time.
    localparam logic [15:0] TIMEOUT_DATA = 16'h002f;

    // Level code 0..3 maps onto bus request levels BR4..BR7.
    localparam logic [2:0] BR_BASE = 3'd4;

endpackage

// File: rtl/iopage_irq_arb.sv
// Interrupt arbiter: eligibility vs cpu_ipl, highest-level/lowest-index pick, frozen grant.
// Latency: request to interrupt 1 cycle; ack to irq_ack pulse 1 cycle, then a 1-cycle quiet gap.
// Backpressure: a posted grant holds until int_ack or until it becomes ineligible (withdraw).
// Ports: irq_req_i/irq_level_i/irq_vector_i per channel, cpu_ipl_i, int_ack_i in;
//        interrupt_o, interrupt_ipl_o (one-hot), vector_o, irq_ack_o out.
module iopage_irq_arb
    import iopage_pkg::*;
#(
    parameter int NIRQ  = 4,
    parameter int VEC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NIRQ-1:0]       irq_req_i,
    input  logic [2*NIRQ-1:0]     irq_level_i,
    input  logic [VEC_W*NIRQ-1:0] irq_vector_i,
    input  logic [2:0]            cpu_ipl_i,
    input  logic                  int_ack_i,
    output logic                  interrupt_o,
    output logic [7:0]            interrupt_ipl_o,
    output logic [VEC_W-1:0]      vector_o,
    output logic [NIRQ-1:0]       irq_ack_o
);

    localparam int IDX_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    irq_state_t       state_q, state_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [1:0]       lvl_q, lvl_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [NIRQ-1:0]  ack_q, ack_d;

    logic [NIRQ-1:0]  elig;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [1:0]       pick_lvl;
    logic [VEC_W-1:0] pick_vec;

    // Eligibility and priority pick. Strict '>' keeps the lowest index on ties.
    always_comb begin
        elig     = '0;
        pick_any = 1'b0;
        pick_idx = '0;
        pick_lvl = '0;
        pick_vec = '0;
        for (int i = 0; i < NIRQ; i++) begin
            elig[i] = irq_req_i[i] &&
                      (({1'b0, irq_level_i[2*i +: 2]} + BR_BASE) > cpu_ipl_i);
            if (elig[i] && (!pick_any || (irq_level_i[2*i +: 2] > pick_lvl))) begin
                pick_any = 1'b1;
                pick_idx = IDX_W'(i);
                pick_lvl = irq_level_i[2*i +: 2];
                pick_vec = irq_vector_i[VEC_W*i +: VEC_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        lvl_d   = lvl_q;
        vec_d   = vec_q;
        ack_d   = '0;
        case (state_q)
            I_IDLE: begin
                if (pick_any) begin
                    win_d   = pick_idx;
                    lvl_d   = pick_lvl;
                    vec_d   = pick_vec;
                    state_d = I_POST;
                end
            end
            I_POST: begin
                // Ack takes precedence over a same-cycle withdrawal.
                if (int_ack_i) begin
                    ack_d[win_q] = 1'b1;
                    state_d      = I_HOLD;
                end else if (!elig[win_q]) begin
                    state_d = I_IDLE;
                end
            end
            I_HOLD:  state_d = I_IDLE;
            default: state_d = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= I_IDLE;
            win_q   <= '0;
            lvl_q   <= '0;
            vec_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            lvl_q   <= lvl_d;
            vec_q   <= vec_d;
            ack_q   <= ack_d;
        end
    end

    assign interrupt_o     = (state_q == I_POST);
    assign interrupt_ipl_o = interrupt_o ? 8'(8'h01 << ({1'b0, lvl_q} + BR_BASE)) : 8'h00;
    assign vector_o        = interrupt_o ? vec_q : '0;
    assign irq_ack_o       = ack_q;

endmodule

// File: rtl/iopage_fabric.sv
// I/O-page fabric: slave decode/select, registered read data, wait states, bus timeout, irq arbitration.
// Latency: zero-wait cycle completes 2 cycles after cyc rises; no decode times out TIMEOUT+1 cycles after cyc.
// Backpressure: slv_ready stretches the cycle up to the timeout; a finished cycle holds until cyc drops.
// Ports: CPU side iopage_rd/iopage_wr, data_out, io_done, no_decode; slave side slv_decode/slv_ready/slv_data;
//        interrupt side irq_req/irq_level/irq_vector, cpu_ipl, int_ack, interrupt, interrupt_ipl, vector, irq_ack.
module iopage_fabric
    import iopage_pkg::*;
#(
    parameter int NSLV    = 8,
    parameter int NIRQ    = 4,
    parameter int TIMEOUT = 15,
    parameter int VEC_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iopage_rd,
    input  logic                  iopage_wr,
    input  logic [NSLV-1:0]       slv_decode,
    input  logic [NSLV-1:0]       slv_ready,
    input  logic [16*NSLV-1:0]    slv_data,
    output logic [15:0]           data_out,
    output logic                  io_done,
    output logic                  no_decode,
    input  logic [NIRQ-1:0]       irq_req,
    input  logic [2*NIRQ-1:0]     irq_level,
    input  logic [VEC_W*NIRQ-1:0] irq_vector,
    input  logic [2:0]            cpu_ipl,
    input  logic                  int_ack,
    output logic                  interrupt,
    output logic [7:0]            interrupt_ipl,
    output logic [VEC_W-1:0]      vector,
    output logic [NIRQ-1:0]       irq_ack
);

    localparam int         SEL_W   = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic cyc;
    assign cyc = iopage_rd | iopage_wr;

    bus_state_t       bstate_q, bstate_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             hit_q, hit_d;
    logic             rd_q, rd_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [15:0]      data_q, data_d;
    logic             done_q, done_d;
    logic             nodec_q, nodec_d;

    logic [SEL_W-1:0] first_hit;
    logic [15:0]      sel_data;

    // Lowest-index decode wins: scan downward so the last assignment is the lowest set bit.
    always_comb begin
        first_hit = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (slv_decode[i]) first_hit = SEL_W'(i);
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == SEL_W'(i)) sel_data = slv_data[16*i +: 16];
        end
    end

    always_comb begin
        bstate_d = bstate_q;
        sel_d    = sel_q;
        hit_d    = hit_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        done_d   = 1'b0;
        nodec_d  = 1'b0;
        case (bstate_q)
            B_IDLE: begin
                if (cyc) begin
                    sel_d    = first_hit;
                    hit_d    = |slv_decode;
                    rd_d     = iopage_rd;
                    cnt_d    = '0;
                    bstate_d = B_WAIT;
                end
            end
            B_WAIT: begin
                if (!cyc) begin
                    // CPU abandoned the cycle: no completion pulse of either kind.
                    bstate_d = B_IDLE;
                end else if (hit_q && slv_ready[sel_q]) begin
                    if (rd_q) data_d = sel_data;
                    done_d   = 1'b1;
                    bstate_d = B_DONE;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d    = cnt_q + 8'd1;
                    data_d   = TIMEOUT_DATA;
                    nodec_d  = 1'b1;
                    bstate_d = B_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            B_DONE: begin
                if (!cyc) bstate_d = B_IDLE;
            end
            default: bstate_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bstate_q <= B_IDLE;
            sel_q    <= '0;
            hit_q    <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            nodec_q  <= 1'b0;
        end else begin
            bstate_q <= bstate_d;
            sel_q    <= sel_d;
            hit_q    <= hit_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            done_q   <= done_d;
            nodec_q  <= nodec_d;
        end
    end

    assign data_out  = data_q;
    assign io_done   = done_q;
    assign no_decode = nodec_q;

    iopage_irq_arb #(
        .NIRQ  (NIRQ),
        .VEC_W (VEC_W)
    ) u_irq_arb (
        .clk             (clk),
        .rst_n           (reset),
        .irq_req_i       (irq_req),
        .irq_level_i     (irq_level),
        .irq_vector_i    (irq_vector),
        .cpu_ipl_i       (cpu_ipl),
        .int_ack_i       (int_ack),
        .interrupt_o     (interrupt),
        .interrupt_ipl_o (interrupt_ipl),
        .vector_o        (vector),
        .irq_ack_o       (irq_ack)
    );

endmodule

// File: doc/iopage_fabric.md
Name: iopage_fabric

Overview:
- Parametrised I/O-page bus fabric: decodes, muxes and times out CPU I/O-page cycles across NSLV slave register blocks, and arbitrates NIRQ device interrupt requests by BR level.
- Sits between the CPU bus unit and the device register blocks (bootrom, mmu, tt, clk, sr, psw, rk, and later devices).
- Adds behaviour the previous combinational decoder lacked: registered read data, slave wait-states, bus timeout, per-channel programmable BR level, CPU-priority masking, and a frozen-grant ack handshake.

Parameters:
- NSLV, 8, number of slave register blocks.
- NIRQ, 4, number of interrupt channels.
- TIMEOUT, 15, cycles to wait for slave ready before no_decode; range 1..255.
- VEC_W, 8, vector width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; fabric is in reset while reset=0.
- iopage_rd  in  1  CPU I/O-page read, level, held until io_done/no_decode seen.
- iopage_wr  in  1  CPU I/O-page write, level.
- slv_decode  in  NSLV  per-slave address hit.
- slv_ready  in  NSLV  per-slave cycle complete; slaves with no wait states tie to 1.
- slv_data  in  16*NSLV  slave read data; slave i on bits [16i+15:16i].
- data_out  out  16  registered read data.
- io_done  out  1  one-cycle pulse: cycle completed.
- no_decode  out  1  one-cycle pulse: bus timeout.
- irq_req  in  NIRQ  device interrupt request, level.
- irq_level  in  2*NIRQ  per-channel BR level code 0..3 = BR4..BR7.
- irq_vector  in  VEC_W*NIRQ  per-channel vector.
- cpu_ipl  in  3  current processor priority from psw[7:5].
- int_ack  in  1  CPU acknowledge pulse.
- interrupt  out  1  request to CPU.
- interrupt_ipl  out  8  one-hot level of the posted request.
- vector  out  VEC_W  vector of the posted request.
- irq_ack  out  NIRQ  one-cycle ack to the granted channel.

Behaviour:
- Reset: every output is 0; both FSMs go to IDLE; timeout counter is 0.
- Bus FSM states are B_IDLE, B_WAIT and B_DONE. Let cyc = iopage_rd|iopage_wr.
- B_IDLE, cyc=1: latch sel = lowest-index set bit of slv_decode; record hit = |slv_decode; clear the counter; go to B_WAIT.
- B_WAIT, hit and slv_ready[sel] = 1: data_out <= slv_data[sel] (reads only; unchanged on writes); pulse io_done; go to B_DONE.
- B_WAIT otherwise: increment the counter. When the counter reaches TIMEOUT, pulse no_decode, leave data_out at 16'h002f, and go to B_DONE. A missing decode therefore gives no_decode exactly TIMEOUT+1 cycles after cyc rises.
- Zero-wait latency: cyc rises at edge n, io_done is high after edge n+2.
- B_DONE: hold until cyc=0, then go to B_IDLE. A new cycle requires cyc to drop first.
- cyc dropping in B_WAIT: abort to B_IDLE with no pulse.
- slv_decode and slv_ready are sampled only in B_IDLE and B_WAIT. sel is frozen for the whole cycle.
- Interrupt FSM states are I_IDLE, I_POST and I_HOLD. Channel i is eligible when irq_req[i] and (irq_level[i]+4) > cpu_ipl.
- I_IDLE: if any channel is eligible, win = the highest level, ties broken by lowest index. Register win, its vector and its level; go to I_POST.
- I_POST: interrupt = 1, interrupt_ipl = 1<<(level+4), vector stable. The grant stays frozen even if a higher request arrives.
- I_POST, int_ack: pulse irq_ack[win] for one cycle and go to I_HOLD.
- I_POST, no ack and win becomes ineligible (req dropped or cpu_ipl raised): withdraw. interrupt, interrupt_ipl and vector clear next cycle; go to I_IDLE; no irq_ack.
- I_POST, int_ack in the same cycle as a withdrawal: the ack wins.
- I_HOLD: outputs 0 for one cycle so the device can drop req; then go to I_IDLE.
- Request to interrupt latency: 1 cycle.
- The bus FSM and interrupt FSM are independent; simultaneous activity is legal.

Decomposition:
- Package iopage_pkg holds the bus state enum, the interrupt state enum, the constant TIMEOUT_DATA=16'h002f, and the BR level base constant 4.
- One sub-module, iopage_irq_arb: the eligibility mask, the priority pick and the interrupt FSM.
- The bus FSM stays in the top module.

Test Plan:
- Read with slv_decode=8'b0000_0100, ready=1, slave2 data=16'o012345: data_out=16'o012345 and io_done high 2 cycles after rd rises; no no_decode.
- Read with slv_decode=8'b0001_0010: slave1 is selected.
- Read with slv_decode=0: no_decode pulses once, 16 cycles after rd (TIMEOUT=15); data_out=16'h002f; holding rd gives no second pulse.
- Write to slave 3 with ready low 5 cycles then high: io_done 1 cycle after ready rises; data_out unchanged.
- Channels 0 (BR4, vec 060) and 2 (BR6, vec 100) request together, cpu_ipl=0: vector=0100, interrupt_ipl=8'h40. After int_ack, irq_ack=4'b0100 for one cycle, I_HOLD for one cycle, then vector=060 with ipl 8'h10.
- Channel 1 at BR5 posted, then cpu_ipl set to 5: interrupt drops the next cycle with no irq_ack. Setting cpu_ipl back to 4 reposts it.
- Reset driven 0 mid-B_WAIT and in I_POST: all outputs read 0 immediately; after reset=1 with cyc still high, a fresh cycle starts.
